// File: rtl/i2c_pkg.sv
// Shared I2C definitions: R/W bit encoding and the register-target FSM state type.
package i2c_pkg;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAckChk,
    StIgnore
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronises raw SCL/SDA into clk and flags SCL edges and START/STOP conditions.
module i2c_bus_sampler (
  input  logic clk,
  input  logic reset,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;

  // Reset to the idle-bus level so leaving reset never looks like a START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_raw};
      sda_sync <= {sda_sync[0], sda_raw};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign sda       = sda_sync[1];
  assign scl_rise  = scl_sync[1] & ~scl_prev;
  assign scl_fall  = ~scl_sync[1] & scl_prev;
  assign start_det = scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
  assign stop_det  = scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];

endmodule

// File: rtl/i2c_register_target.sv
// I2C target exposing a byte-wide register file with pointer auto-increment,
// plus a local host port into the same registers.
module i2c_register_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h68,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned PTR_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2c_scl,
  inout  wire              i2c_sda,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  input  logic             host_we,
  output logic [7:0]       host_rdata,
  output logic             reg_wr_strobe,
  output logic [PTR_W-1:0] reg_wr_index,
  output logic             addressed,
  output logic             bus_busy
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .scl_raw   (i2c_scl),
    .sda_raw   (i2c_sda),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_e   state;
  logic [7:0]       regs [NUM_REGS];
  logic [PTR_W-1:0] ptr;
  logic [3:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic [7:0]       tx_shift;
  logic             sda_low;
  logic             first_byte;
  logic [7:0]       cur_reg;

  assign cur_reg = regs[ptr];
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      regs          <= '{default: 8'h00};
      ptr           <= '0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      sda_low       <= 1'b0;
      first_byte    <= 1'b0;
      addressed     <= 1'b0;
      bus_busy      <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_wr_index  <= '0;
      host_rdata    <= '0;
    end else begin
      reg_wr_strobe <= 1'b0;
      host_rdata    <= regs[host_addr];
      // Host write sits first so a same-index I2C commit below overrides it.
      if (host_we) regs[host_addr] <= host_wdata;

      if (stop_det) begin
        state     <= StIdle;
        sda_low   <= 1'b0;
        addressed <= 1'b0;
        bus_busy  <= 1'b0;
      end else if (start_det) begin
        state     <= StAddr;
        bit_cnt   <= '0;
        sda_low   <= 1'b0;
        addressed <= 1'b0;
        bus_busy  <= 1'b1;
      end else begin
        unique case (state)
          StIdle, StIgnore: ;
          StAddr: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[6:0], sda};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (rx_shift[7:1] == TARGET_ADDR) begin
                sda_low   <= 1'b1;
                addressed <= 1'b1;
                state     <= StAddrAck;
              end else begin
                state <= StIgnore;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (rx_shift[0] == I2C_READ) begin
                tx_shift <= {cur_reg[6:0], 1'b0};
                sda_low  <= ~cur_reg[7];
                ptr      <= ptr + 1'b1;
                bit_cnt  <= 4'd1;
                state    <= StRdByte;
              end else begin
                sda_low    <= 1'b0;
                first_byte <= 1'b1;
                bit_cnt    <= '0;
                state      <= StWrByte;
              end
            end
          end
          StWrByte: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[6:0], sda};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_low <= 1'b1;
              state   <= StWrAck;
              if (first_byte) begin
                ptr        <= rx_shift[PTR_W-1:0];
                first_byte <= 1'b0;
              end else begin
                regs[ptr]     <= rx_shift;
                reg_wr_strobe <= 1'b1;
                reg_wr_index  <= ptr;
                ptr           <= ptr + 1'b1;
              end
            end
          end
          StWrAck: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
              state   <= StWrByte;
            end
          end
          StRdByte: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
                state   <= StRdAckChk;
              end else begin
                sda_low  <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          StRdAckChk: begin
            // NACK ends the read at once; an ACK continues on the following SCL fall.
            if (scl_rise && sda) begin
              addressed <= 1'b0;
              state     <= StIgnore;
            end else if (scl_fall) begin
              tx_shift <= {cur_reg[6:0], 1'b0};
              sda_low  <= ~cur_reg[7];
              ptr      <= ptr + 1'b1;
              bit_cnt  <= 4'd1;
              state    <= StRdByte;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_register_target.sv
// Directed bench: bit-bangs I2C transactions at the target and checks bus and host behaviour.
module tb_i2c_register_target;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       scl        = 1'b1;
  logic       sda_low    = 1'b0;
  logic [3:0] host_addr  = 4'd0;
  logic [7:0] host_wdata = 8'h00;
  logic       host_we    = 1'b0;
  logic [7:0] host_rdata;
  logic       reg_wr_strobe;
  logic [3:0] reg_wr_index;
  logic       addressed;
  logic       bus_busy;
  wire        i2c_sda;

  int checks = 0;
  int passes = 0;
  logic [3:0] strobe_log [$];

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  always #5 clk = ~clk;

  always @(negedge clk) if (reg_wr_strobe === 1'b1) strobe_log.push_back(reg_wr_index);

  i2c_register_target #(
    .TARGET_ADDR (7'h68),
    .NUM_REGS    (16),
    .PTR_W       (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i2c_scl       (scl),
    .i2c_sda       (i2c_sda),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_we       (host_we),
    .host_rdata    (host_rdata),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_index  (reg_wr_index),
    .addressed     (addressed),
    .bus_busy      (bus_busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit slot: SCL low 5 clk, high 4 clk; sample mid-high.
  task automatic bit_xfer(input logic b, output logic r);
    sda_low = ~b;
    tick(4);
    scl = 1'b1;
    tick(2);
    r = i2c_sda;
    tick(2);
    scl = 1'b0;
    tick(1);
  endtask

  task automatic i2c_start();
    sda_low = 1'b1;
    tick(4);
    scl = 1'b0;
    tick(1);
  endtask

  task automatic i2c_rstart();
    sda_low = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(4);
    sda_low = 1'b1;
    tick(4);
    scl = 1'b0;
    tick(1);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(4);
    sda_low = 1'b0;
    tick(4);
  endtask

  // Optionally holds host_we on (ca, cd) across the commit of this byte.
  task automatic write_byte(input logic [7:0] b, input logic collide, input logic [3:0] ca,
                            input logic [7:0] cd, output logic acked);
    logic r;
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      if (collide && i == 0) begin
        host_addr  = ca;
        host_wdata = cd;
        host_we    = 1'b1;
      end
      bit_xfer(b[i], r);
    end
    if (collide) begin
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        if (reg_wr_strobe === 1'b1) seen = 1'b1;
        else tick(1);
      end
      host_we = 1'b0;
      checks++;
      if (seen !== 1'b1) $display("FAIL collide_strobe: strobe seen=%b, required 1", seen);
      else passes++;
    end
    bit_xfer(1'b1, r);
    acked = (r === 1'b0);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick(1);
    host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    tick(1);
    d = host_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    tick(3);
    checks++;
    if (i2c_sda !== 1'b1) $display("FAIL reset_sda: got %b, required 1", i2c_sda);
    else passes++;
    checks++;
    if ({addressed, bus_busy, reg_wr_strobe} !== 3'b000)
      $display("FAIL reset_flags: got %b, required 000", {addressed, bus_busy, reg_wr_strobe});
    else passes++;
    checks++;
    if (host_rdata !== 8'h00) $display("FAIL reset_rdata: got %h, required 00", host_rdata);
    else passes++;
    reset = 1'b0;
    tick(2);
    host_read(4'd9, d);
    checks++;
    if (d !== 8'h00) $display("FAIL reset_reg9: got %h, required 00", d);
    else passes++;
  endtask

  task automatic test_write_ptr();
    logic a0, a1;
    strobe_log.delete();
    i2c_start();
    checks++;
    if (bus_busy !== 1'b1) $display("FAIL wp_busy: got %b, required 1", bus_busy);
    else passes++;
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    checks++;
    if (addressed !== 1'b1) $display("FAIL wp_addressed: got %b, required 1", addressed);
    else passes++;
    write_byte(8'h27, 1'b0, 4'd0, 8'h00, a1);
    i2c_stop();
    checks++;
    if ({a0, a1} !== 2'b11) $display("FAIL wp_acks: got %b, required 11", {a0, a1});
    else passes++;
    checks++;
    if (dut.ptr !== 4'd7) $display("FAIL wp_ptr: got %0d, required 7", dut.ptr);
    else passes++;
    checks++;
    if (strobe_log.size() != 0) $display("FAIL wp_nostrobe: got %0d strobes, required 0",
                                         strobe_log.size());
    else passes++;
    checks++;
    if ({addressed, bus_busy} !== 2'b00)
      $display("FAIL wp_stop_flags: got %b, required 00", {addressed, bus_busy});
    else passes++;
  endtask

  task automatic test_reg_write();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    strobe_log.delete();
    i2c_start();
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    write_byte(8'h03, 1'b0, 4'd0, 8'h00, a1);
    write_byte(8'hA5, 1'b0, 4'd0, 8'h00, a2);
    write_byte(8'h5A, 1'b0, 4'd0, 8'h00, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111)
      $display("FAIL rw_acks: got %b, required 1111", {a0, a1, a2, a3});
    else passes++;
    checks++;
    if (strobe_log.size() != 2 || strobe_log[0] !== 4'd3 || strobe_log[1] !== 4'd4)
      $display("FAIL rw_strobes: got %p, required '{3, 4}", strobe_log);
    else passes++;
    host_read(4'd3, d);
    checks++;
    if (d !== 8'hA5) $display("FAIL rw_reg3: got %h, required a5", d);
    else passes++;
    host_read(4'd4, d);
    checks++;
    if (d !== 8'h5A) $display("FAIL rw_reg4: got %h, required 5a", d);
    else passes++;
  endtask

  task automatic test_read_rs();
    logic a0, a1, a2;
    logic [7:0] d;
    host_write(4'd7, 8'h11);
    host_write(4'd8, 8'h22);
    i2c_start();
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    write_byte(8'h27, 1'b0, 4'd0, 8'h00, a1);
    i2c_rstart();
    write_byte(8'hD1, 1'b0, 4'd0, 8'h00, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b111) $display("FAIL rd_acks: got %b, required 111", {a0, a1, a2});
    else passes++;
    read_byte(1'b0, d);
    checks++;
    if (d !== 8'h11) $display("FAIL rd_byte0: got %h, required 11", d);
    else passes++;
    read_byte(1'b1, d);
    checks++;
    if (d !== 8'h22) $display("FAIL rd_byte1: got %h, required 22", d);
    else passes++;
    checks++;
    if ({i2c_sda, addressed} !== 2'b10)
      $display("FAIL rd_nack_release: sda/addressed got %b, required 10", {i2c_sda, addressed});
    else passes++;
    i2c_stop();
    checks++;
    if (dut.ptr !== 4'd9) $display("FAIL rd_ptr: got %0d, required 9", dut.ptr);
    else passes++;
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    logic [7:0] d;
    strobe_log.delete();
    i2c_start();
    write_byte(8'hA0, 1'b0, 4'd0, 8'h00, a0);
    checks++;
    if (addressed !== 1'b0) $display("FAIL wa_addressed: got %b, required 0", addressed);
    else passes++;
    write_byte(8'h55, 1'b0, 4'd0, 8'h00, a1);
    i2c_stop();
    checks++;
    if ({a0, a1} !== 2'b00) $display("FAIL wa_nack: acks got %b, required 00", {a0, a1});
    else passes++;
    checks++;
    if (strobe_log.size() != 0 || dut.ptr !== 4'd9)
      $display("FAIL wa_nochange: strobes %0d ptr %0d, required 0 and 9",
               strobe_log.size(), dut.ptr);
    else passes++;
    host_read(4'd5, d);
    checks++;
    if (d !== 8'h00) $display("FAIL wa_reg5: got %h, required 00", d);
    else passes++;
  endtask

  task automatic test_wrap_collision();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    strobe_log.delete();
    i2c_start();
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    write_byte(8'h0F, 1'b0, 4'd0, 8'h00, a1);
    write_byte(8'hEE, 1'b1, 4'd1, 8'h3C, a2);
    write_byte(8'hFF, 1'b1, 4'd0, 8'h77, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111)
      $display("FAIL wc_acks: got %b, required 1111", {a0, a1, a2, a3});
    else passes++;
    checks++;
    if (strobe_log.size() != 2 || strobe_log[0] !== 4'd15 || strobe_log[1] !== 4'd0)
      $display("FAIL wc_strobes: got %p, required '{15, 0}", strobe_log);
    else passes++;
    host_read(4'd15, d);
    checks++;
    if (d !== 8'hEE) $display("FAIL wc_reg15: got %h, required ee", d);
    else passes++;
    host_read(4'd0, d);
    checks++;
    if (d !== 8'hFF) $display("FAIL wc_reg0_i2c_wins: got %h, required ff", d);
    else passes++;
    host_read(4'd1, d);
    checks++;
    if (d !== 8'h3C) $display("FAIL wc_reg1_host: got %h, required 3c", d);
    else passes++;
    checks++;
    if (dut.ptr !== 4'd1) $display("FAIL wc_ptr: got %0d, required 1", dut.ptr);
    else passes++;
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3, r;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    write_byte(8'h02, 1'b0, 4'd0, 8'h00, a1);
    i2c_rstart();
    write_byte(8'hD1, 1'b0, 4'd0, 8'h00, a2);
    bit_xfer(1'b1, r);
    bit_xfer(1'b1, r);
    checks++;
    if (i2c_sda !== 1'b0) $display("FAIL rm_driven: sda got %b, required 0", i2c_sda);
    else passes++;
    reset = 1'b1;
    tick(1);
    checks++;
    if (i2c_sda !== 1'b1) $display("FAIL rm_release: sda got %b, required 1", i2c_sda);
    else passes++;
    checks++;
    if ({addressed, bus_busy, reg_wr_strobe, host_rdata} !== 11'd0)
      $display("FAIL rm_outputs: got %b/%b/%b/%h, required 0/0/0/00",
               addressed, bus_busy, reg_wr_strobe, host_rdata);
    else passes++;
    reset = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(8);
    host_read(4'd3, d);
    checks++;
    if (d !== 8'h00) $display("FAIL rm_reg3_cleared: got %h, required 00", d);
    else passes++;
    strobe_log.delete();
    i2c_start();
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    write_byte(8'h06, 1'b0, 4'd0, 8'h00, a1);
    write_byte(8'h81, 1'b0, 4'd0, 8'h00, a2);
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b111 || strobe_log.size() != 1 || strobe_log[0] !== 4'd6)
      $display("FAIL rm_after_write: acks %b strobes %p, required 111 and '{6}",
               {a0, a1, a2}, strobe_log);
    else passes++;
    i2c_start();
    write_byte(8'hD0, 1'b0, 4'd0, 8'h00, a0);
    write_byte(8'h06, 1'b0, 4'd0, 8'h00, a1);
    i2c_rstart();
    write_byte(8'hD1, 1'b0, 4'd0, 8'h00, a3);
    read_byte(1'b1, d);
    i2c_stop();
    checks++;
    if (d !== 8'h81 || {a0, a1, a3} !== 3'b111)
      $display("FAIL rm_after_read: got %h acks %b, required 81 and 111", d, {a0, a1, a3});
    else passes++;
    checks++;
    if (bus_busy !== 1'b0) $display("FAIL rm_final_busy: got %b, required 0", bus_busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write_ptr();
    test_reg_write();
    test_read_rs();
    test_wrong_addr();
    test_wrap_collision();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
